// File: rtl/fifo_tap_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_tap_reader_if
// Output stream bundle of the tap reader: one signed tap value per transfer,
// with a last-element qualifier and a valid/ready handshake.
//   out_valid  master->slave  out_data holds a tap value
//   out_ready  slave->master  consumer accepts when out_valid && out_ready
//   out_data   master->slave  signed tap value
//   out_last   master->slave  final element of the burst
// -----------------------------------------------------------------------------
interface fifo_tap_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo_tap_reader.sv
// -----------------------------------------------------------------------------
// fifo_tap_reader
// Read-side sequencer for the shift-register tap FIFO of the PE scratchpad.
// On start it walks reg_select across num_taps taps from base_tap and streams
// each tap value out at up to one element per cycle. FIFO pushes that happen
// mid-burst move the window toward higher indices; the walk follows them so
// every element of the original window is read exactly once, and a pending
// element pushed out of the FIFO ends the burst with err set.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   start        begin a burst (only honoured in IDLE)
//   base_tap     first tap index, sampled with start
//   num_taps     tap count 0..DEPTH, sampled with start
//   fifo_shift   FIFO load enable; contents move up one index at next edge
//   reg_select   tap index driven to the FIFO
//   value_in     FIFO tap value for reg_select (combinational in the FIFO)
//   out_if       output stream (valid/ready/data/last), master side
//   busy         high while the burst is running or draining
//   done         one-cycle pulse at burst end (normal or aborted)
//   err          sticky range/overflow error, cleared by the next start
//
// Optional build macro TAP_READER_ACCUM_EN adds out_sum: signed running sum
// of all accepted elements of the burst, cleared on start, reset to 0.
// -----------------------------------------------------------------------------
module fifo_tap_reader #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_tap,
    input  logic [ADDR_WIDTH:0]          num_taps,
    input  logic                         fifo_shift,
    output logic [ADDR_WIDTH-1:0]        reg_select,
    input  logic signed [DATA_WIDTH-1:0] value_in,
    fifo_tap_reader_if.master            out_if,
    output logic                         busy,
    output logic                         done,
    output logic                         err
`ifdef TAP_READER_ACCUM_EN
    ,
    output logic signed [DATA_WIDTH+ADDR_WIDTH:0] out_sum
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH:0]   LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH+1:0] DEPTH_W  = (ADDR_WIDTH+2)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   REM_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH:0]          rem_q, rem_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic                         err_q, err_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic                         issue_s;
    logic [ADDR_WIDTH:0]          idx_next_s;
    logic [ADDR_WIDTH:0]          rem_next_s;
    logic                         range_bad_s;

`ifdef TAP_READER_ACCUM_EN
    localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH + 1;
    logic signed [SUM_W-1:0] sum_q, sum_d;
`endif

    // Issue, index-tracking and start range arithmetic shared by the FSM.
    always_comb begin
        issue_s = (state_q == S_RUN) && (!valid_q || out_if.out_ready);
        // The tap read this cycle is pre-shift; a push moves the window up by one.
        idx_next_s = {1'b0, idx_q} + {{ADDR_WIDTH{1'b0}}, issue_s}
                   + {{ADDR_WIDTH{1'b0}}, fifo_shift};
        if (issue_s) begin
            rem_next_s = rem_q - REM_ONE;
        end else begin
            rem_next_s = rem_q;
        end
        range_bad_s = ({2'b00, base_tap} + {1'b0, num_taps}) > DEPTH_W;
    end

    // Next-state and datapath logic of the burst sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;
`ifdef TAP_READER_ACCUM_EN
        if (valid_q && out_if.out_ready) begin
            sum_d = sum_q + {{(SUM_W-DATA_WIDTH){data_q[DATA_WIDTH-1]}}, data_q};
        end else begin
            sum_d = sum_q;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    idx_d = base_tap;
                    rem_d = num_taps;
`ifdef TAP_READER_ACCUM_EN
                    sum_d = '0;
`endif
                    if (num_taps == REM_ZERO) begin
                        state_d = S_DONE;
                    end else if (range_bad_s) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s) begin
                    data_d  = value_in;
                    valid_d = 1'b1;
                    last_d  = (rem_q == REM_ONE);
                end else begin
                    valid_d = valid_q;
                end
                idx_d = idx_next_s[ADDR_WIDTH-1:0];
                rem_d = rem_next_s;
                if (rem_next_s == REM_ZERO) begin
                    state_d = S_DRAIN;
                end else if (idx_next_s > LAST_IDX) begin
                    // A pending tap was pushed out: close the burst on the held element.
                    err_d   = 1'b1;
                    last_d  = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!valid_q || out_if.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef TAP_READER_ACCUM_EN
    // Burst accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign out_sum = sum_q;
`endif

    assign reg_select       = idx_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_fifo_tap_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_tap_reader
// Directed bench for fifo_tap_reader. A small FIFO model supplies value_in:
// orig[] holds the original contents and shift_cnt counts pushes, so tap i
// currently holds orig[i - shift_cnt] (or the pushed-in value 100).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_fifo_tap_reader;

    localparam int AW = 3;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_tap;
    logic [AW:0]          num_taps;
    logic                 fifo_shift;
    logic [AW-1:0]        reg_select;
    logic signed [DW-1:0] value_in;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef TAP_READER_ACCUM_EN
    logic signed [DW+AW:0] out_sum;
`endif

    fifo_tap_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_tap_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_tap   (base_tap),
        .num_taps   (num_taps),
        .fifo_shift (fifo_shift),
        .reg_select (reg_select),
        .value_in   (value_in),
        .out_if     (bus.master),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef TAP_READER_ACCUM_EN
        ,
        .out_sum    (out_sum)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model
    logic signed [DW-1:0] orig [8];
    int                   shift_cnt;
    logic                 fifo_clr;

    always @(posedge clk) begin
        if (fifo_clr) shift_cnt <= 0;
        else if (fifo_shift) shift_cnt <= shift_cnt + 1;
    end

    always_comb begin
        if (int'(reg_select) >= shift_cnt) value_in = orig[int'(reg_select) - shift_cnt];
        else value_in = 16'sd100;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        orig[0] = 16'sd10;  orig[1] = -16'sd3; orig[2] = 16'sd7;  orig[3] = 16'sd2;
        orig[4] = 16'sd5;   orig[5] = -16'sd8; orig[6] = 16'sd11; orig[7] = -16'sd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic signed [DW-1:0] exp2 [3];
        logic [15:0]          pat;
        logic                 prev_stall;
        logic signed [DW-1:0] prev_data;
        logic                 prev_last;
        int                   k;
        int                   n_done;
        int                   n_valid;

        load_default();
        rst = 1'b1; start = 1'b0; base_tap = '0; num_taps = '0;
        fifo_shift = 1'b0; fifo_clr = 1'b1; bus.out_ready = 1'b1;
        step(); step();

        // Reset values
        check("rst_reg_select", reg_select, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0; fifo_clr = 1'b0;

        // Test 1: base=1 num=3, full rate; start held high while busy (ignored)
        base_tap = 3'd1; num_taps = 4'd3; start = 1'b1;
        step();
        check("t1_busy_c1", busy, 1);
        check("t1_valid_c1", bus.out_valid, 0);
        check("t1_sel_c1", reg_select, 1);
        base_tap = 3'd5; num_taps = 4'd1;
        step();
        check("t1_valid_a", bus.out_valid, 1);
        check("t1_data_a", bus.out_data, -3);
        check("t1_last_a", bus.out_last, 0);
        step();
        check("t1_data_b", bus.out_data, 7);
        check("t1_last_b", bus.out_last, 0);
        step();
        check("t1_data_c", bus.out_data, 2);
        check("t1_last_c", bus.out_last, 1);
        check("t1_busy_c", busy, 1);
        step();
        check("t1_valid_end", bus.out_valid, 0);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_err", err, 0);
        start = 1'b0;
        step();
        check("t1_done_pulse", done, 0);
        check("t1_ignored_busy", busy, 0);
        check("t1_ignored_valid", bus.out_valid, 0);

        // Test 2: same burst with back-pressure
        exp2[0] = -16'sd3; exp2[1] = 16'sd7; exp2[2] = 16'sd2;
        pat = 16'b1111_1111_1010_1001;
        base_tap = 3'd1; num_taps = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        k = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.out_ready = pat[i];
            if (bus.out_valid) begin
                if (prev_stall) begin
                    check("t2_hold_data", bus.out_data, prev_data);
                    check("t2_hold_last", bus.out_last, prev_last);
                end
                if (bus.out_ready && k < 3) begin
                    check("t2_xfer_data", bus.out_data, exp2[k]);
                    check("t2_xfer_last", bus.out_last, (k == 2) ? 1 : 0);
                    k++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            step();
        end
        check("t2_count", k, 3);
        check("t2_idle", busy, 0);
        bus.out_ready = 1'b1;

        // Test 3: push during first issue, base=2 num=3
        fifo_clr = 1'b1; step(); fifo_clr = 1'b0;
        base_tap = 3'd2; num_taps = 4'd3; start = 1'b1;
        step();
        start = 1'b0; fifo_shift = 1'b1;
        step();
        fifo_shift = 1'b0;
        check("t3_data_a", bus.out_data, 7);
        check("t3_sel_b", reg_select, 4);
        step();
        check("t3_data_b", bus.out_data, 2);
        check("t3_sel_c", reg_select, 5);
        step();
        check("t3_data_c", bus.out_data, 5);
        check("t3_last_c", bus.out_last, 1);
        step();
        check("t3_done", done, 1);
        check("t3_err", err, 0);

        // Test 4: overflow, base=6 num=2 with push during first issue
        fifo_clr = 1'b1; step(); fifo_clr = 1'b0;
        base_tap = 3'd6; num_taps = 4'd2; start = 1'b1;
        step();
        start = 1'b0; fifo_shift = 1'b1;
        step();
        fifo_shift = 1'b0;
        check("t4_valid", bus.out_valid, 1);
        check("t4_data", bus.out_data, 11);
        check("t4_last", bus.out_last, 1);
        check("t4_err", err, 1);
        step();
        check("t4_valid_end", bus.out_valid, 0);
        check("t4_done", done, 1);
        check("t4_err_hold", err, 1);
        step();
        check("t4_done_pulse", done, 0);

        // Test 5a: range error base=5 num=4
        fifo_clr = 1'b1;
        base_tap = 3'd5; num_taps = 4'd4; start = 1'b1;
        step();
        start = 1'b0; fifo_clr = 1'b0;
        check("t5_range_done", done, 1);
        check("t5_range_err", err, 1);
        check("t5_range_valid", bus.out_valid, 0);
        step();
        check("t5_err_sticky", err, 1);
        check("t5_range_busy", busy, 0);

        // Test 5b: num=0 -> one done pulse, no data, err cleared
        base_tap = 3'd3; num_taps = 4'd0; start = 1'b1;
        n_done = 0; n_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            start = 1'b0;
            if (done) n_done++;
            if (bus.out_valid) n_valid++;
        end
        check("t5_zero_done_cnt", n_done, 1);
        check("t5_zero_valid_cnt", n_valid, 0);
        check("t5_zero_err", err, 0);

        // Test 6: reset after 1 of 4 transfers
        base_tap = 3'd0; num_taps = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t6_first", bus.out_data, 10);
        step();
        check("t6_second", bus.out_data, -3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_data", bus.out_data, 0);
        check("t6_rst_last", bus.out_last, 0);
        check("t6_rst_sel", reg_select, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) n_done++;
        end
        check("t6_no_done", n_done, 0);

`ifdef TAP_READER_ACCUM_EN
        // Accumulator: burst {4,-9,1} sums to -4
        orig[0] = 16'sd4; orig[1] = -16'sd9; orig[2] = 16'sd1;
        base_tap = 3'd0; num_taps = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        check("acc_done", done, 1);
        check("acc_sum", out_sum, -4);
        load_default();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
